// File: rtl/sys_array_conv_param.sv
// sys_array_conv_param
//   K x N grid of signed multiply-accumulate PEs.  Each accepted input beat
//   adds w[i]*p[i+j] into acc[i][j].  After ACC_LEN beats the columns are
//   reduced by a registered adder tree of L = ceil(log2(K)) levels, and the
//   N results are offered behind a valid/ready handshake.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous abort of the current window
//   relu_en         clamp negative results to 0 (latched on the final beat)
//   in_valid/ready  input beat handshake
//   para_pixel_i    (K+N-1) signed pixels, p[m] at [(m+1)*DW-1 -: DW]
//   para_weight_i   K signed weights, w[i] at [(i+1)*DW-1 -: DW]
//   out_valid/ready output handshake for conv_o
//   conv_o          N signed results, column j at [(j+1)*AW-1 -: AW]
//   busy            high unless idle in ACC with no beats collected
module sys_array_conv_param #(
   parameter int DW      = 8,
   parameter int AW      = 32,
   parameter int K       = 11,
   parameter int N       = 20,
   parameter int ACC_LEN = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  relu_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [(K+N-1)*DW-1:0] para_pixel_i,
   input  logic [K*DW-1:0]       para_weight_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*AW-1:0]       conv_o,
   output logic                  busy
);

   localparam int L   = $clog2(K);
   localparam int BW  = $clog2(ACC_LEN + 1);
   localparam int DCW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         beat_cnt;
   logic [DCW-1:0]        drain_cnt;
   logic                  relu_q;
   logic                  accept;
   logic                  last_beat;
   logic                  clr_acc;

   logic signed [AW-1:0]  acc_p0 [K][N];
   logic signed [AW-1:0]  tree_p [1:L][N][K];
   // Source operands of each tree level, zero padded to 2*K so that an odd
   // leftover simply adds zero and passes through its level register.
   logic signed [AW-1:0]  lvl_in [L][N][2*K];

   // Signed DW x DW product, sign-extended to the accumulator width.
   function automatic logic signed [AW-1:0] mac_term(input logic signed [DW-1:0] w,
                                                     input logic signed [DW-1:0] p);
      logic signed [2*DW-1:0] prod;
      prod = w * p;
      return AW'(prod);
   endfunction

   function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] x,
                                                 input logic en);
      return (en && (x < 0)) ? '0 : x;
   endfunction

   // Live operand count at tree level l: ceil(K / 2^l).
   function automatic int lvl_cnt(input int l);
      return (K + (1 << l) - 1) >> l;
   endfunction

   assign accept    = in_valid & in_ready;
   assign last_beat = (beat_cnt == BW'(ACC_LEN - 1));
   assign clr_acc   = out_valid & out_ready;
   assign busy      = !((state_q == ST_ACC) && (beat_cnt == '0));

   // Control: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_ACC;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_ACC: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_cnt == DCW'(L - 1)) state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_ACC;
         end
         default: state_d = ST_ACC;
      endcase
      if (flush) state_d = ST_ACC;
   end

   // Control: beat / drain counters and relu latch
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         if (state_q == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                     drain_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                   relu_q <= 1'b0;
      else if (accept && last_beat && !flush)    relu_q <= relu_en;
   end

   // Stage p0: PE accumulators
   always_ff @(posedge clk) begin
      if (rst || flush || clr_acc) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < N; j++)
               acc_p0[i][j] <= '0;
      end else if (accept) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < N; j++)
               acc_p0[i][j] <= acc_p0[i][j] +
                               mac_term(para_weight_i[i*DW +: DW],
                                        para_pixel_i[(i+j)*DW +: DW]);
      end
   end

   always_comb begin
      for (int l = 0; l < L; l++)
         for (int j = 0; j < N; j++)
            for (int e = 0; e < 2*K; e++)
               lvl_in[l][j][e] = '0;
      for (int j = 0; j < N; j++)
         for (int i = 0; i < K; i++)
            lvl_in[0][j][i] = acc_p0[i][j];
      for (int l = 1; l < L; l++)
         for (int j = 0; j < N; j++)
            for (int e = 0; e < K; e++)
               lvl_in[l][j][e] = tree_p[l][j][e];
   end

   // Stages p1..pL: registered column adder tree, relu on the last level
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int l = 1; l <= L; l++)
            for (int j = 0; j < N; j++)
               for (int e = 0; e < K; e++)
                  tree_p[l][j][e] <= '0;
      end else begin
         for (int l = 1; l <= L; l++)
            for (int j = 0; j < N; j++)
               for (int e = 0; e < K; e++) begin
                  if (e < lvl_cnt(l)) begin
                     if (l == L)
                        tree_p[l][j][e] <= relu(lvl_in[l-1][j][2*e] + lvl_in[l-1][j][2*e+1], relu_q);
                     else
                        tree_p[l][j][e] <= lvl_in[l-1][j][2*e] + lvl_in[l-1][j][2*e+1];
                  end else begin
                     tree_p[l][j][e] <= '0;
                  end
               end
      end
   end

   always_comb begin
      conv_o = '0;
      for (int j = 0; j < N; j++)
         conv_o[j*AW +: AW] = tree_p[L][j][0];
   end

endmodule

// File: doc/sys_array_conv_param.md
# sys_array_conv_param

Parametrised, handshaked successor of the first-layer systolic convolution array. A K×N grid of signed multiply-accumulate PEs accumulates one convolution row-window per accepted input beat over ACC_LEN beats. It then reduces each output column through a registered adder tree and presents N results behind a valid/ready output handshake. It sits between the line-buffer pixel/weight feeder and the pooling/activation stage.

## Interface

Parameters:
- DW, 8: signed pixel and weight width.
- AW, 32: signed accumulator and output width; must be ≥ 2·DW.
- K, 11: kernel taps per beat (PE rows); must be ≥ 2.
- N, 20: output columns (PE columns).
- ACC_LEN, 11: beats accumulated per output; must be ≥ 1.

Derived: L = ceil(log2(K)), the adder-tree register levels (4 at default).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous abort of the current window.
- relu_en  in  1  clamps negative results to 0; sampled on the final accepted beat of a window.
- in_valid  in  1  beat present.
- in_ready  out  1  array accepts a beat.
- para_pixel_i  in  (K+N-1)·DW  pixel p[m] at bits [(m+1)·DW-1 -: DW].
- para_weight_i  in  K·DW  weight w[i] at bits [(i+1)·DW-1 -: DW].
- out_valid  out  1  conv_o holds a finished window.
- out_ready  in  1  downstream accepts conv_o.
- conv_o  out  N·AW  column j result at bits [(j+1)·AW-1 -: AW].
- busy  out  1  high whenever the FSM is not in ACC with beat_cnt = 0.

## Operation

- PE(i,j) computes w[i]·p[i+j] as a signed 2·DW-bit product, sign-extends it to AW, and adds it into acc[i][j] on each accepted beat. A beat is accepted when in_valid & in_ready.
- All accumulator and tree additions are two's complement and wrap modulo 2^AW. There is no saturation.
- Column j result is Σ over i=0..K-1 of acc[i][j]. The tree pairs operands level by level and registers each level; an odd leftover passes through that level's register.
- relu_en (latched) is applied at the final tree level: a negative result becomes 0.
- FSM states and transitions:
  - ACC: in_ready = 1. Each accepted beat increments beat_cnt. The beat that makes beat_cnt reach ACC_LEN moves the FSM to DRAIN and resets beat_cnt to 0.
  - DRAIN: in_ready = 0. The state lasts exactly L cycles, advancing the tree, then moves to OUT.
  - OUT: out_valid = 1 and conv_o is held stable. On out_ready the FSM clears all accumulators and returns to ACC.
- in_ready is 0 in DRAIN and OUT. An input beat is never accepted in the same cycle as the output handshake.
- flush, in any state, takes effect at the next edge: accumulators, tree registers and beat_cnt are cleared; the FSM goes to ACC; out_valid drops; a pending result is discarded. flush overrides a simultaneous input acceptance or output handshake.
- rst has the same effect as flush and additionally clears the relu_en latch.

## Timing

- Reset values: in_ready = 1 (state ACC), out_valid = 0, busy = 0, conv_o = 0, all accumulators and tree registers 0, beat_cnt = 0.
- If the final beat is accepted at edge t, out_valid is high from edge t+L onward (4 cycles at defaults) and stays high until the out_ready edge.
- If out_ready is high at edge u, out_valid is low and in_ready is high from edge u; a beat can be accepted at edge u+1.
- With ACC_LEN = 1 and out_ready tied high, peak throughput is one window per L+2 cycles.
- With out_ready low, conv_o and out_valid hold indefinitely and no beats are accepted.

## Test plan

1. Defaults with ACC_LEN=1, w[i]=1, p[m]=m, one beat -> conv_o[j] = 55+11j (col0 = 55, col19 = 264); out_valid rises 4 edges after the accept.
2. ACC_LEN=3, w=-1, p=127, three beats, relu_en=0 -> every column = -4191. Repeating with relu_en=1 on the final beat -> every column = 0.
3. Backpressure: hold out_ready low for 5 cycles with in_valid high -> in_ready = 0 throughout, conv_o stable. After the handshake, the next window of test 1 yields 55…264 again, confirming accumulators were cleared.
4. flush after the 2nd of 3 beats, then 3 fresh beats of test 2 -> result -4191 (not -6985). flush asserted during OUT drops out_valid at the next edge.
5. Wrap: AW=16, K=11, w=-128, p=-128, ACC_LEN=1 -> each column = 180224 mod 65536 = 49152, i.e. -16384 signed.
6. rst asserted during DRAIN -> at the next edge out_valid = 0, in_ready = 1, busy = 0. A following test 1 window yields the correct sums.
